// File: rtl/capture_controller.sv
// Capture controller: streams pre/post-trigger samples into the sample RAM, then
// reads a programmed number of samples back out to the serial transmitter.
module capture_controller #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          validIn,
  input  logic [DW-1:0] dataIn,
  input  logic          capture,
  input  logic          run,
  input  logic          wrSize,
  input  logic [31:0]   config_data,
  input  logic          busy,
  input  logic [DW-1:0] memoryRdData,
  output logic          memoryWrite,
  output logic [DW-1:0] memoryWrData,
  output logic          memoryRead,
  output logic          memoryLastWrite,
  output logic          send,
  output logic [DW-1:0] sendData,
  output logic          active
);

  typedef enum logic [2:0] {StIdle, StSample, StDelay, StRead, StReadWait} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] fwd_cfg_q, fwd_cfg_d, read_cfg_q, read_cfg_d;
  logic [CW-1:0] fwd_q, fwd_d, read_q, read_d;
  logic [CW-1:0] counter_q, counter_d;
  logic          mem_write_q, mem_write_d;
  logic [DW-1:0] mem_wr_data_q, mem_wr_data_d;
  logic          mem_read_q, mem_read_d;
  logic          last_write_q, last_write_d;
  logic          send_q, send_d;
  logic          active_q, active_d;

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    fwd_d         = fwd_q;
    read_d        = read_q;
    fwd_cfg_d     = wrSize ? CW'(config_data[31:16]) : fwd_cfg_q;
    read_cfg_d    = wrSize ? CW'(config_data[15:0]) : read_cfg_q;
    mem_write_d   = 1'b0;
    mem_wr_data_d = mem_wr_data_q;
    mem_read_d    = 1'b0;
    last_write_d  = 1'b0;
    send_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Sizes are snapshotted here so a mid-run wrSize cannot disturb the run.
        if (capture) begin
          state_d   = StSample;
          counter_d = '0;
          fwd_d     = fwd_cfg_d;
          read_d    = read_cfg_d;
        end
      end
      StSample: begin
        if (validIn) begin
          mem_write_d   = 1'b1;
          mem_wr_data_d = dataIn;
        end
        if (run) begin
          state_d   = StDelay;
          counter_d = '0;
        end
      end
      StDelay: begin
        if (validIn) begin
          mem_write_d   = 1'b1;
          mem_wr_data_d = dataIn;
          if (counter_q == fwd_q) begin
            last_write_d = 1'b1;
            counter_d    = '0;
            state_d      = StRead;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
      end
      StRead: begin
        // send_q is the strobe currently on the output, i.e. the previous cycle
        // from the point of view of the read strobe being scheduled.
        if (!busy && !send_q) begin
          mem_read_d = 1'b1;
          state_d    = StReadWait;
        end
      end
      StReadWait: begin
        send_d = 1'b1;
        if (counter_q == read_q) begin
          counter_d = '0;
          state_d   = StIdle;
        end else begin
          counter_d = counter_q + 1'b1;
          state_d   = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign active_d = (state_d != StIdle) || (state_q != StIdle);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      fwd_cfg_q     <= '0;
      read_cfg_q    <= '0;
      fwd_q         <= '0;
      read_q        <= '0;
      counter_q     <= '0;
      mem_write_q   <= 1'b0;
      mem_wr_data_q <= '0;
      mem_read_q    <= 1'b0;
      last_write_q  <= 1'b0;
      send_q        <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fwd_cfg_q     <= fwd_cfg_d;
      read_cfg_q    <= read_cfg_d;
      fwd_q         <= fwd_d;
      read_q        <= read_d;
      counter_q     <= counter_d;
      mem_write_q   <= mem_write_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_read_q    <= mem_read_d;
      last_write_q  <= last_write_d;
      send_q        <= send_d;
      active_q      <= active_d;
    end
  end

  assign memoryWrite     = mem_write_q;
  assign memoryWrData    = mem_wr_data_q;
  assign memoryRead      = mem_read_q;
  assign memoryLastWrite = last_write_q;
  assign send            = send_q;
  // RAM data arrives the cycle after memoryRead, which is exactly the send cycle.
  assign sendData        = send_q ? memoryRdData : '0;
  assign active          = active_q;

endmodule

// File: tb/tb_capture_controller.sv
// Scoreboard bench for capture_controller: expected writes/sends are queued by the
// stimulus and popped by a monitor whenever the DUT strobes.
`timescale 1ns/1ps
module tb_capture_controller;
  localparam int DW = 32;
  localparam int W  = DW + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          validIn = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic          capture = 1'b0;
  logic          run = 1'b0;
  logic          wrSize = 1'b0;
  logic [31:0]   config_data = '0;
  logic          busy = 1'b0;
  logic [DW-1:0] memoryRdData;
  logic          memoryWrite, memoryRead, memoryLastWrite, send, active;
  logic [DW-1:0] memoryWrData, sendData;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  wr_q[$];
  logic [DW-1:0] send_q[$];
  int            wr_cyc[$];
  int            rd_ptr;
  int            rd_seen = 0;
  int            rd_base = 0;
  int            cyc = 0;
  int            exp_rd = 0;

  capture_controller #(.DW(DW), .CW(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .validIn        (validIn),
    .dataIn         (dataIn),
    .capture        (capture),
    .run            (run),
    .wrSize         (wrSize),
    .config_data    (config_data),
    .busy           (busy),
    .memoryRdData   (memoryRdData),
    .memoryWrite    (memoryWrite),
    .memoryWrData   (memoryWrData),
    .memoryRead     (memoryRead),
    .memoryLastWrite(memoryLastWrite),
    .send           (send),
    .sendData       (sendData),
    .active         (active)
  );

  always #5 clock = ~clock;

  // RAM model: returns a recognisable pattern, one cycle after each read strobe.
  always @(posedge clock) begin
    if (memoryRead) begin
      memoryRdData <= 32'hD000_0000 + DW'(rd_ptr);
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic prev_send = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      chk("rd_wr_exclusive", W'(memoryWrite & memoryRead), W'(1'b0));
      chk("send_gap", W'(send & prev_send), W'(1'b0));
      prev_send = send;
      if (memoryRead) rd_seen++;
      if (memoryWrite) begin
        wr_cyc.push_back(cyc);
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %h, expected no write", memoryWrData);
        end else begin
          chk("write", {memoryLastWrite, memoryWrData}, wr_q.pop_front());
        end
      end else begin
        chk("lastwrite_alone", W'(memoryLastWrite), W'(1'b0));
      end
      if (send) begin
        if (send_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_send: got %h, expected no send", sendData);
        end else begin
          chk("send_data", W'(sendData), W'(send_q.pop_front()));
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic cap, input logic rn);
    validIn = v;
    dataIn  = d;
    capture = cap;
    run     = rn;
    @(posedge clock);
    #1;
  endtask

  task automatic exp_wr(input logic last, input logic [DW-1:0] d);
    wr_q.push_back({last, d});
  endtask

  task automatic exp_send();
    send_q.push_back(32'hD000_0000 + DW'(exp_rd));
    exp_rd++;
  endtask

  task automatic set_size(input logic [31:0] c);
    wrSize      = 1'b1;
    config_data = c;
    @(posedge clock);
    #1;
    wrSize = 1'b0;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_strobes"}, W'({memoryWrite, memoryRead, memoryLastWrite, send, active}),
        W'(5'b0));
    chk({name, "_wrdata"}, W'(memoryWrData), W'(0));
    chk({name, "_senddata"}, W'(sendData), W'(0));
  endtask

  task automatic drain(input string name, input int exp_reads);
    int n = 0;
    while ((wr_q.size() != 0 || send_q.size() != 0) && n < 400) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    chk_int({name, "_drained"}, wr_q.size() + send_q.size(), 0);
    chk_int({name, "_reads"}, rd_seen - rd_base, exp_reads);
    chk({name, "_idle"}, W'(active), W'(1'b0));
    rd_base = rd_seen;
  endtask

  task automatic stimulus();
    int n;
    // Reset values with validIn toggling and capture asserted.
    for (int i = 0; i < 3; i++) begin
      step(i[0], 32'h5500 + DW'(i), 1'b1, 1'b1);
      @(negedge clock);
      chk_quiet("reset_hold");
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) step(1'b1, 32'h77, 1'b0, 1'b0);
    @(negedge clock);
    chk_quiet("after_release");

    // Basic capture: fwd=3, read=1.
    set_size(32'h0003_0001);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) exp_wr(i == 6, 32'hA0 + DW'(i));
    for (int i = 0; i < 7; i++) step(1'b1, 32'hA0 + DW'(i), 1'b0, i == 2);
    exp_send();
    exp_send();
    step(1'b1, 32'hEE, 1'b0, 1'b1);
    drain("basic", 2);

    // Busy handshake: fwd=1, read=0.
    step(1'b0, '0, 1'b0, 1'b0);
    set_size(32'h0001_0000);
    step(1'b0, '0, 1'b1, 1'b0);
    exp_wr(1'b0, 32'hB0);
    exp_wr(1'b0, 32'hB1);
    exp_wr(1'b1, 32'hB2);
    step(1'b1, 32'hB0, 1'b0, 1'b1);
    step(1'b1, 32'hB1, 1'b0, 1'b0);
    busy = 1'b1;
    step(1'b1, 32'hB2, 1'b0, 1'b0);
    validIn = 1'b0;
    exp_send();
    repeat (10) begin
      @(negedge clock);
      chk("busy_noread", W'(memoryRead), W'(1'b0));
    end
    @(posedge clock);
    #1;
    busy = 1'b0;
    @(negedge clock);
    chk("busy_drop_same", W'(memoryRead), W'(1'b0));
    @(negedge clock);
    chk("busy_drop_read", W'(memoryRead), W'(1'b1));
    @(negedge clock);
    chk("busy_drop_send", W'(send), W'(1'b1));
    drain("busy", 1);

    // Minimum sizes.
    set_size(32'h0000_0000);
    step(1'b0, '0, 1'b1, 1'b0);
    exp_wr(1'b0, 32'hC0);
    exp_wr(1'b1, 32'hC1);
    exp_send();
    step(1'b1, 32'hC0, 1'b0, 1'b1);
    step(1'b1, 32'hC1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    drain("min", 1);

    // Sparse valid in DELAY: fwd=2.
    set_size(32'h0002_0000);
    step(1'b0, '0, 1'b1, 1'b0);
    exp_wr(1'b0, 32'hE0);
    step(1'b1, 32'hE0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      exp_wr(k == 3, 32'hE0 + DW'(k));
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 32'hE0 + DW'(k), 1'b0, 1'b0);
    end
    exp_send();
    step(1'b0, '0, 1'b0, 1'b0);
    drain("sparse", 1);
    n = wr_cyc.size();
    chk_int("sparse_gap1", wr_cyc[n-3] - wr_cyc[n-4], 3);
    chk_int("sparse_gap2", wr_cyc[n-2] - wr_cyc[n-3], 3);
    chk_int("sparse_gap3", wr_cyc[n-1] - wr_cyc[n-2], 3);

    // Reset during DELAY after two post-trigger writes.
    set_size(32'h0005_0000);
    step(1'b0, '0, 1'b1, 1'b0);
    exp_wr(1'b0, 32'hF0);
    exp_wr(1'b0, 32'hF1);
    exp_wr(1'b0, 32'hF2);
    step(1'b1, 32'hF0, 1'b0, 1'b1);
    step(1'b1, 32'hF1, 1'b0, 1'b0);
    step(1'b1, 32'hF2, 1'b0, 1'b0);
    dataIn = 32'hF3;
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk_quiet("reset_mid");
    repeat (2) begin
      @(posedge clock);
      #1;
      validIn = ~validIn;
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (10) step(1'b1, 32'hBAD, 1'b0, 1'b1);
    drain("reset_mid", 0);
    chk_int("total_reads", rd_seen, exp_rd);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
